vliw_wb_scoreboard: RTL and testbench

- Parametrised issue/writeback tracker for the VLIW core; generalises the fixed per-unit destination delay lines to NUM_LANES lanes, each with its own latency.
- Sits between ID and the register-file write ports.
- Holds a per-register outstanding-write count.
- Stalls any issue packet with a RAW/WAW hazard, then delivers each lane's destination and write-enable exactly LAT cycles after issue.

---
 rtl/vliw_wb_scoreboard.sv | 148 ++++++++++++++
 tb/tb_vliw_wb_scoreboard.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_wb_scoreboard.sv
// Issue/writeback scoreboard for the VLIW core: blocks RAW/WAW hazards at issue and
// replays each lane's destination exactly LANE_LAT[i] cycles after the packet is accepted.
module vliw_wb_scoreboard #(
   parameter int                           NUM_LANES = 4,
   parameter int                           REG_AW    = 5,
   parameter int                           LAT_W     = 5,
   parameter logic [NUM_LANES*LAT_W-1:0]   LANE_LAT  = {5'd26, 5'd13, 5'd4, 5'd4},
   parameter int                           CNT_W     = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            issue_valid,
   output logic                            issue_ready,
   input  logic [NUM_LANES*REG_AW-1:0]     issue_dst,
   input  logic [NUM_LANES-1:0]            issue_dst_en,
   input  logic [2*NUM_LANES*REG_AW-1:0]   issue_src,
   input  logic [2*NUM_LANES-1:0]          issue_src_en,
   output logic [NUM_LANES-1:0]            wb_valid,
   output logic [NUM_LANES*REG_AW-1:0]     wb_dst,
   output logic [(2**REG_AW)-1:0]          busy,
   output logic [15:0]                     stall_cnt
);

   localparam int NUM_REGS = 2**REG_AW;

   logic [CNT_W-1:0]     count_q [NUM_REGS];
   logic [CNT_W-1:0]     count_d [NUM_REGS];
   logic [CNT_W-1:0]     ret_n   [NUM_REGS];
   logic [NUM_REGS-1:0]  eff_busy;
   logic [NUM_LANES-1:0] lane_en;
   logic                 hazard;
   logic                 accept;
   logic [15:0]          stall_cnt_q;
   logic [15:0]          stall_cnt_d;

   // Retire-adjusted view: a register whose last write retires this cycle is free now.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         ret_n[r] = '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            if (wb_valid[i] && (wb_dst[i*REG_AW +: REG_AW] == REG_AW'(r))) begin
               ret_n[r] = ret_n[r] + CNT_W'(1);
            end
         end
         eff_busy[r] = ((count_q[r] - ret_n[r]) != '0);
      end
   end

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (issue_src_en[2*i+k] && eff_busy[issue_src[(2*i+k)*REG_AW +: REG_AW]]) begin
               hazard = 1'b1;
            end
         end
         if (issue_dst_en[i] && (issue_dst[i*REG_AW +: REG_AW] != '0) &&
             eff_busy[issue_dst[i*REG_AW +: REG_AW]]) begin
            hazard = 1'b1;
         end
      end
   end

   // Handshake: a packet transfers on a rising edge where issue_valid and issue_ready are
   // both high; issue_ready is combinational and never depends on issue_valid.
   assign issue_ready = rst_n & ~flush & ~hazard;
   assign accept      = issue_valid & issue_ready;

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_en[i] = accept & issue_dst_en[i] & (issue_dst[i*REG_AW +: REG_AW] != '0);
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         count_d[r] = count_q[r] - ret_n[r];
         for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_en[i] && (issue_dst[i*REG_AW +: REG_AW] == REG_AW'(r))) begin
               count_d[r] = count_d[r] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            count_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            count_q[r] <= count_d[r];
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         busy[r] = (count_q[r] != '0);
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (issue_valid && !issue_ready && !flush && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

   // One delay line per lane, depth equal to that lane's latency; entries are {en, dst}.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam int D = int'(LANE_LAT[i*LAT_W +: LAT_W]);

      logic [REG_AW:0] pipe_q [D];
      logic [REG_AW:0] lane_in_d;

      assign lane_in_d = lane_en[i] ? {1'b1, issue_dst[i*REG_AW +: REG_AW]} : '0;

      always_ff @(posedge clk) begin
         if (!rst_n || flush) begin
            for (int s = 0; s < D; s++) begin
               pipe_q[s] <= '0;
            end
         end else begin
            pipe_q[0] <= lane_in_d;
            for (int s = 1; s < D; s++) begin
               pipe_q[s] <= pipe_q[s-1];
            end
         end
      end

      assign wb_valid[i]                 = pipe_q[D-1][REG_AW];
      assign wb_dst[i*REG_AW +: REG_AW]  = pipe_q[D-1][REG_AW-1:0];
   end

endmodule

// File: tb/tb_vliw_wb_scoreboard.sv
// Bench for vliw_wb_scoreboard: directed scenarios plus random traffic, checked against
// a list-of-scheduled-writebacks reference model.
module tb_vliw_wb_scoreboard;

   localparam int NL = 4;
   localparam int AW = 5;
   localparam int NR = 32;
   localparam int PW = 1 + NL + NL*AW + NR + 16;
   localparam int LAT [NL] = '{4, 4, 13, 26};

   logic               clk = 1'b0;
   logic               rst_n;
   logic               flush;
   logic               issue_valid;
   logic               issue_ready;
   logic [NL*AW-1:0]   issue_dst;
   logic [NL-1:0]      issue_dst_en;
   logic [2*NL*AW-1:0] issue_src;
   logic [2*NL-1:0]    issue_src_en;
   logic [NL-1:0]      wb_valid;
   logic [NL*AW-1:0]   wb_dst;
   logic [NR-1:0]      busy;
   logic [15:0]        stall_cnt;

   vliw_wb_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_dst(issue_dst), .issue_dst_en(issue_dst_en),
      .issue_src(issue_src), .issue_src_en(issue_src_en),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .busy(busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: every accepted write is a record due in a known cycle.
   typedef struct { int ret; int lane; int dst; } wb_t;
   wb_t exp_q[$];
   int  cyc = 0;
   int  m_stall = 0;
   int  n_checks = 0;
   int  n_err = 0;

   logic             exp_ready;
   logic [NL-1:0]    exp_wbv;
   logic [NL*AW-1:0] exp_wbd;
   logic [NR-1:0]    exp_busy;

   task automatic model_eval();
      int  cnt [NR];
      bit  eff [NR];
      bit  haz;
      for (int r = 0; r < NR; r++) begin cnt[r] = 0; eff[r] = 0; end
      exp_wbv = '0; exp_wbd = '0;
      foreach (exp_q[j]) begin
         if (exp_q[j].ret == cyc) begin
            exp_wbv[exp_q[j].lane] = 1'b1;
            exp_wbd[exp_q[j].lane*AW +: AW] = AW'(exp_q[j].dst);
         end
         if (exp_q[j].ret >= cyc) cnt[exp_q[j].dst]++;
         if (exp_q[j].ret > cyc) eff[exp_q[j].dst] = 1;
      end
      for (int r = 0; r < NR; r++) exp_busy[r] = (cnt[r] != 0);
      haz = 0;
      for (int s = 0; s < 2*NL; s++)
         if (issue_src_en[s] && eff[issue_src[s*AW +: AW]]) haz = 1;
      for (int i = 0; i < NL; i++)
         if (issue_dst_en[i] && issue_dst[i*AW +: AW] != 0 && eff[issue_dst[i*AW +: AW]]) haz = 1;
      exp_ready = rst_n & ~flush & ~haz;
   endtask

   task automatic tick();
      wb_t e;
      model_eval();
      if (!rst_n) begin
         exp_q.delete(); m_stall = 0;
      end else if (flush) begin
         exp_q.delete();
      end else begin
         for (int j = exp_q.size() - 1; j >= 0; j--)
            if (exp_q[j].ret == cyc) exp_q.delete(j);
         if (issue_valid && exp_ready) begin
            for (int i = 0; i < NL; i++) begin
               if (issue_dst_en[i] && issue_dst[i*AW +: AW] != 0) begin
                  e.ret = cyc + LAT[i]; e.lane = i; e.dst = int'(issue_dst[i*AW +: AW]);
                  exp_q.push_back(e);
               end
            end
         end else if (issue_valid && m_stall < 65535) begin
            m_stall++;
         end
      end
      @(posedge clk); #1; cyc++;
   endtask

   task automatic idle();
      issue_valid = 0; flush = 0;
      issue_dst = '0; issue_dst_en = '0; issue_src = '0; issue_src_en = '0;
   endtask

   task automatic set_dst(input int lane, input int r);
      issue_dst[lane*AW +: AW] = AW'(r); issue_dst_en[lane] = 1'b1;
   endtask

   task automatic set_src(input int slot, input int r);
      issue_src[slot*AW +: AW] = AW'(r); issue_src_en[slot] = 1'b1;
   endtask

   task automatic drain(input int n);
      idle();
      repeat (n) tick();
   endtask

   function automatic logic [PW-1:0] act_pack();
      return {issue_ready, wb_valid, wb_dst, busy, stall_cnt};
   endfunction

   function automatic logic [PW-1:0] exp_pack();
      return {exp_ready, exp_wbv, exp_wbd, exp_busy, 16'(m_stall)};
   endfunction

   task automatic test_reset();
      rst_n = 0; idle(); issue_valid = 1; set_dst(0, 5);
      repeat (2) tick();
      rst_n = 1; idle(); #1; model_eval();
      n_checks++;
      if ({wb_valid, wb_dst, busy, stall_cnt} !== '0 || issue_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state wbv=%b wbd=%h busy=%h stall=%0d ready=%b required all zero, ready=1",
                  wb_valid, wb_dst, busy, stall_cnt, issue_ready);
      end
   endtask

   task automatic test_single();
      int lat = -1; logic [AW-1:0] got = '0;
      idle(); issue_valid = 1; set_dst(0, 5); #1; model_eval();
      n_checks++;
      if (act_pack() !== exp_pack()) begin
         n_err++; $display("FAIL single cyc=%0d dut=%h ref=%h", cyc, act_pack(), exp_pack());
      end
      tick(); idle();
      for (int c = 1; c <= 8; c++) begin
         #1; model_eval(); n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_err++; $display("FAIL single cyc=%0d dut=%h ref=%h", cyc, act_pack(), exp_pack());
         end
         if (wb_valid[0] && lat < 0) begin lat = c; got = wb_dst[AW-1:0]; end
         tick();
      end
      n_checks++;
      if (lat !== 4 || got !== 5'd5) begin
         n_err++; $display("FAIL single_latency lat=%0d dst=%0d required lat=4 dst=5", lat, got);
      end
   endtask

   task automatic test_raw();
      int stalls = 0; bit acc = 0; int s0;
      idle(); issue_valid = 1; set_dst(2, 7); tick();
      idle(); issue_valid = 1; set_src(0, 7); set_dst(0, 8);
      s0 = m_stall;
      for (int c = 0; c < 20 && !acc; c++) begin
         #1; model_eval(); n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_err++; $display("FAIL raw cyc=%0d dut=%h ref=%h", cyc, act_pack(), exp_pack());
         end
         if (issue_ready) begin
            acc = 1; n_checks++;
            if (wb_valid[2] !== 1'b1 || wb_dst[2*AW +: AW] !== 5'd7) begin
               n_err++; $display("FAIL raw_accept_on_retire wbv2=%b dst=%0d required 1 and 7",
                                 wb_valid[2], wb_dst[2*AW +: AW]);
            end
         end else stalls++;
         tick();
      end
      n_checks++;
      if (stalls != 12 || !acc || stall_cnt !== 16'(s0 + 12)) begin
         n_err++; $display("FAIL raw_stalls stalls=%0d acc=%0d stall_cnt=%0d required 12 1 %0d",
                           stalls, acc, stall_cnt, s0 + 12);
      end
      drain(30);
   endtask

   task automatic test_waw();
      idle(); issue_valid = 1; set_dst(0, 9); set_dst(1, 9); set_src(0, 9); #1; model_eval();
      n_checks++;
      if (act_pack() !== exp_pack() || issue_ready !== 1'b1) begin
         n_err++; $display("FAIL waw_issue cyc=%0d dut=%h ref=%h", cyc, act_pack(), exp_pack());
      end
      tick(); idle();
      for (int c = 1; c <= 8; c++) begin
         #1; model_eval(); n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_err++; $display("FAIL waw cyc=%0d dut=%h ref=%h", cyc, act_pack(), exp_pack());
         end
         if (c == 4) begin
            n_checks++;
            if (wb_valid[1:0] !== 2'b11 || wb_dst[2*AW-1:0] !== {5'd9, 5'd9} || busy[9] !== 1'b1) begin
               n_err++; $display("FAIL waw_retire wbv=%b wbd=%h busy9=%b required 11 129 1",
                                 wb_valid, wb_dst, busy[9]);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (busy[9] !== 1'b0) begin
               n_err++; $display("FAIL waw_clear busy9=%b required 0", busy[9]);
            end
         end
         tick();
      end
   endtask

   task automatic test_full_occupancy();
      int stalls = 0; int wb3 = 0; int s0 = m_stall;
      for (int c = 0; c < 60; c++) begin
         idle();
         if (c < 30) begin issue_valid = 1; set_dst(3, c + 1); end
         #1; model_eval(); n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_err++; $display("FAIL full cyc=%0d dut=%h ref=%h", cyc, act_pack(), exp_pack());
         end
         if (c < 30 && !issue_ready) stalls++;
         if (wb_valid[3]) wb3++;
         if (c == 26) begin
            n_checks++;
            if ($countones(busy) != 26) begin
               n_err++; $display("FAIL full_depth busy_count=%0d required 26", $countones(busy));
            end
         end
         tick();
      end
      n_checks++;
      if (stalls != 0 || wb3 != 30 || stall_cnt !== 16'(s0)) begin
         n_err++; $display("FAIL full_summary stalls=%0d wb3=%0d stall_cnt=%0d required 0 30 %0d",
                           stalls, wb3, stall_cnt, s0);
      end
   endtask

   task automatic test_flush();
      int wb3 = 0; int s0;
      for (int c = 0; c <= 40; c++) begin
         idle();
         if (c == 0) begin issue_valid = 1; set_dst(3, 3); end
         if (c == 10) begin flush = 1; issue_valid = 1; set_dst(0, 6); s0 = m_stall; end
         #1; model_eval(); n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_err++; $display("FAIL flush cyc=%0d dut=%h ref=%h", cyc, act_pack(), exp_pack());
         end
         if (c == 10) begin
            n_checks++;
            if (issue_ready !== 1'b0 || busy[3] !== 1'b1) begin
               n_err++; $display("FAIL flush_ready ready=%b busy3=%b required 0 1", issue_ready, busy[3]);
            end
         end
         if (c == 11) begin
            n_checks++;
            if (busy !== '0 || stall_cnt !== 16'(s0)) begin
               n_err++; $display("FAIL flush_clear busy=%h stall=%0d required 0 %0d", busy, stall_cnt, s0);
            end
         end
         if (wb_valid[3]) wb3++;
         tick();
      end
      n_checks++;
      if (wb3 != 0) begin
         n_err++; $display("FAIL flush_no_wb wb3=%0d required 0", wb3);
      end
   endtask

   task automatic test_reset_midstream();
      int r0_wb = 0;
      for (int c = 0; c < 40; c++) begin
         idle();
         rst_n = (c != 6);
         if (c < 12 && c != 6) begin
            issue_valid = 1;
            set_dst(0, (c % 3 == 0) ? 0 : 10 + c);
            set_dst(2, 0); set_src(1, 0);
         end
         #1; model_eval(); n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_err++; $display("FAIL rst_mid cyc=%0d dut=%h ref=%h", cyc, act_pack(), exp_pack());
         end
         if (c == 7) begin
            n_checks++;
            if ({wb_valid, wb_dst, busy, stall_cnt} !== '0) begin
               n_err++; $display("FAIL rst_mid_zero wbv=%b wbd=%h busy=%h stall=%0d required 0",
                                 wb_valid, wb_dst, busy, stall_cnt);
            end
         end
         for (int i = 0; i < NL; i++)
            if (wb_valid[i] && wb_dst[i*AW +: AW] == 0) r0_wb++;
         if (busy[0]) r0_wb++;
         tick();
      end
      rst_n = 1;
      n_checks++;
      if (r0_wb != 0) begin
         n_err++; $display("FAIL r0_tracked events=%0d required 0", r0_wb);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         idle();
         issue_valid = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NL; i++)
            if ($urandom_range(0, 1) == 1) set_dst(i, $urandom_range(0, 7));
         for (int s = 0; s < 2*NL; s++)
            if ($urandom_range(0, 2) == 0) set_src(s, $urandom_range(0, 7));
         flush = ($urandom_range(0, 39) == 0);
         #1; model_eval(); n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_err++; $display("FAIL random cyc=%0d dut=%h ref=%h", cyc, act_pack(), exp_pack());
         end
         for (int i = 0; i < NL; i++) begin
            if (wb_valid[i]) begin
               n_checks++;
               if (busy[wb_dst[i*AW +: AW]] !== 1'b1) begin
                  n_err++; $display("FAIL underflow lane=%0d dst=%0d busy=%b required 1",
                                    i, wb_dst[i*AW +: AW], busy[wb_dst[i*AW +: AW]]);
               end
            end
         end
         tick();
      end
      drain(30);
   endtask

   initial begin
      test_reset();
      test_single();
      test_raw();
      test_waw();
      test_full_occupancy();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout cyc=%0d required finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
